// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core with a single shared memory port.
//
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and shares
// one request/ready memory port between instruction fetch and data access.
// Illegal encodings and misaligned data accesses park the core in HALT with
// PC left on the faulting instruction. Retired instructions are counted.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   mem_req/mem_we    request strobe (FETCH, MEM) / store qualifier
//   mem_addr          byte address (PC in FETCH, ALUOut in MEM)
//   mem_wdata/mem_be  lane-replicated store data / little-endian byte enables
//   mem_rdata/mem_ready  read data / completes the pending request this edge
//   Reg_Sel/Reg_Data  combinational debug read of the register file
//   PC, state, halted current instruction address, FSM state, HALT flag
//   instr_count       retired-instruction counter (wraps)
module mc_cpu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  input  logic [4:0]           Reg_Sel,
  output logic [31:0]          Reg_Data,
  output logic [31:0]          PC,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LB   = 6'h20, OP_LH    = 6'h21,
                         OP_LW    = 6'h23, OP_LBU  = 6'h24, OP_LHU   = 6'h25,
                         OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                         F_JR   = 6'h08, F_JALR = 6'h09, F_ADD  = 6'h20,
                         F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
                         F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26,
                         F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic [31:0] regs [32];

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_sext, imm_zext;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign target   = ir_q[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  logic is_rtype, is_jr, is_jalr, is_jump, is_branch, is_load, is_store;
  logic [1:0] ls_size;  // 00 byte, 01 half, 11 word (opcode[1:0] of the MIPS load/store encodings)

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_jr     = is_rtype && ((funct == F_JR) || (funct == F_JALR));
  assign is_jalr   = is_rtype && (funct == F_JALR);
  assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_load   = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                     (opcode == OP_LBU) || (opcode == OP_LHU);
  assign is_store  = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
  assign ls_size   = opcode[1:0];

  logic legal;
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_JALR,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: legal = 1'b1;
          default:       legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU,
      OP_LHU, OP_SB, OP_SH, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Address and control-flow arithmetic
  logic [31:0] eff_addr, pc_plus4, br_target, jmp_target;
  logic        misaligned, taken;

  assign eff_addr   = a_q + imm_sext;
  assign misaligned = ((ls_size == 2'b11) && (eff_addr[1:0] != 2'b00)) ||
                      ((ls_size == 2'b01) && eff_addr[0]);
  assign pc_plus4   = pc_q + 32'd4;
  assign br_target  = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], target, 2'b00};
  assign taken      = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  // ALU (add/sub overflow wraps)
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    if (is_rtype) begin
      case (funct)
        F_ADD, F_ADDU: alu_res = a_q + b_q;
        F_SUB, F_SUBU: alu_res = a_q - b_q;
        F_AND:         alu_res = a_q & b_q;
        F_OR:          alu_res = a_q | b_q;
        F_XOR:         alu_res = a_q ^ b_q;
        F_NOR:         alu_res = ~(a_q | b_q);
        F_SLT:         alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
        F_SLTU:        alu_res = (a_q < b_q) ? 32'd1 : 32'd0;
        F_SLL:         alu_res = b_q << shamt;
        F_SRL:         alu_res = b_q >> shamt;
        F_SRA:         alu_res = $signed(b_q) >>> shamt;
        F_SLLV:        alu_res = b_q << a_q[4:0];
        F_SRLV:        alu_res = b_q >> a_q[4:0];
        F_SRAV:        alu_res = $signed(b_q) >>> a_q[4:0];
        default:       alu_res = '0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU: alu_res = a_q + imm_sext;
        OP_ANDI:           alu_res = a_q & imm_zext;
        OP_ORI:            alu_res = a_q | imm_zext;
        OP_XORI:           alu_res = a_q ^ imm_zext;
        OP_LUI:            alu_res = {imm, 16'h0000};
        OP_SLTI:           alu_res = ($signed(a_q) < $signed(imm_sext)) ? 32'd1 : 32'd0;
        OP_SLTIU:          alu_res = (a_q < imm_sext) ? 32'd1 : 32'd0;
        default:           alu_res = eff_addr;  // loads/stores
      endcase
    end
  end

  // Load lane selection into MDR
  logic [31:0] rd_shift, load_val;
  logic [15:0] rd_half;
  assign rd_shift = mem_rdata >> {alu_out_q[1:0], 3'b000};
  assign rd_half  = alu_out_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  always_comb begin
    load_val = mem_rdata;
    case (ls_size)
      2'b00:   load_val = opcode[2] ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = opcode[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state and control
  logic        ir_we, ab_we, alu_we, mdr_we, retire, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_we    = 1'b0;
    ab_we    = 1'b0;
    alu_we   = 1'b0;
    mdr_we   = 1'b0;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_HALT;
        end else begin
          ab_we   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_we = 1'b1;
        if (is_branch) begin
          pc_d    = taken ? br_target : pc_plus4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jump) begin
          pc_d     = jmp_target;
          rf_we    = (opcode == OP_JAL);
          rf_waddr = 5'd31;
          rf_wdata = pc_plus4;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jr) begin
          pc_d     = a_q;
          rf_we    = is_jalr;
          rf_waddr = rd;
          rf_wdata = pc_plus4;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          // A misaligned access faults here, before any data request goes out.
          state_d = misaligned ? S_HALT : S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_store) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = is_rtype ? rd : rt;
        rf_wdata = is_load ? mdr_q : alu_out_q;
        pc_d     = pc_plus4;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values regardless of statement order.
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      mdr_q       <= '0;
      instr_count <= '0;
    end else begin
      pc_q <= pc_d;
      if (ir_we)  ir_q      <= mem_rdata;
      if (ab_we) begin
        a_q <= regs[rs];
        b_q <= regs[rt];
      end
      if (alu_we) alu_out_q <= alu_res;
      if (mdr_we) mdr_q     <= load_val;
      if (retire) instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this register file is small flops, not a RAM macro, and must come out of reset all-zero, so it is reset explicitly.
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Memory port; request-side strobes are held low while reset is asserted.
  logic in_mem;
  assign in_mem    = (state_q == S_MEM);
  assign mem_req   = rst && ((state_q == S_FETCH) || in_mem);
  assign mem_we    = rst && in_mem && is_store;
  assign mem_addr  = in_mem ? alu_out_q : pc_q;

  always_comb begin
    mem_be = 4'h0;
    if (mem_req) begin
      if (in_mem) begin
        case (ls_size)
          2'b00:   mem_be = 4'b0001 << alu_out_q[1:0];
          2'b01:   mem_be = alu_out_q[1] ? 4'b1100 : 4'b0011;
          default: mem_be = 4'hF;
        endcase
      end else begin
        mem_be = 4'hF;
      end
    end
  end

  always_comb begin
    mem_wdata = b_q;
    case (ls_size)
      2'b00:   mem_wdata = {4{b_q[7:0]}};
      2'b01:   mem_wdata = {2{b_q[15:0]}};
      default: mem_wdata = b_q;
    endcase
  end

  assign Reg_Data = (Reg_Sel == 5'd0) ? 32'd0 : regs[Reg_Sel];
  assign PC       = pc_q;
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: self-checking bench for mc_cpu. A word-wide memory model answers
// the core's port, optionally inserting wait states on data accesses. Expected
// data accesses and final register values are queued when each program is
// loaded and popped as the core produces them.
module tb_mc_cpu;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, Reg_Data, PC, instr_count;
  logic [3:0]  mem_be;
  logic [4:0]  Reg_Sel;
  logic [2:0]  state;

  mc_cpu #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .Reg_Sel(Reg_Sel), .Reg_Data(Reg_Data),
    .PC(PC), .state(state), .halted(halted), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory model and scoreboards
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] v;
  } regexp_t;

  acc_t    acc_q[$];
  regexp_t reg_q[$];

  int          stall_left = 0;
  bit          have_cap = 0;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;

  // Responder: decides mem_ready for the coming edge and scores data accesses.
  initial begin
    acc_t e;
    mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mem_req && state == 3'd3) begin
        if (have_cap) begin
          check("stall_addr_stable", mem_addr, cap_addr);
          check("stall_be_stable", 32'(mem_be), 32'(cap_be));
        end else begin
          have_cap = 1'b1;
          cap_addr = mem_addr;
          cap_be   = mem_be;
        end
        if (stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end else begin
          mem_ready = 1'b1;
          have_cap  = 1'b0;
          check("data_access_expected", 32'(acc_q.size() != 0), 32'd1);
          if (acc_q.size() != 0) begin
            e = acc_q.pop_front();
            check("acc_addr", mem_addr, e.addr);
            check("acc_be", 32'(mem_be), 32'(e.be));
            check("acc_we", 32'(mem_we), 32'(e.we));
            if (e.we) check("acc_wdata", mem_wdata, e.wdata);
          end
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) mem[mem_addr[11:2]][8*i +: 8] = mem_wdata[8*i +: 8];
          end
        end
      end else begin
        mem_ready = 1'b1;
      end
    end
  end

  // Encoders
  function automatic logic [31:0] r_op(input logic [5:0] f, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, f};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  localparam logic [31:0] LOOP = 32'h1000_FFFF;  // beq $0,$0,-1

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask
  task automatic exp_acc(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    acc_t e;
    e = '{we: we, addr: a, be: be, wdata: wd};
    acc_q.push_back(e);
  endtask
  task automatic exp_reg(input logic [4:0] r, input logic [31:0] v);
    regexp_t e;
    e = '{r: r, v: v};
    reg_q.push_back(e);
  endtask

  // Assert reset away from the edge and clear bench state and memory.
  task automatic begin_test();
    @(negedge clk);
    #2;
    rst = 1'b0;
    acc_q.delete();
    reg_q.delete();
    stall_left = 0;
    have_cap   = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  // Hold reset three cycles then release just after a falling edge.
  task automatic release_rst(input int stall);
    repeat (3) @(negedge clk);
    #2;
    stall_left = stall;
    rst = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_count(input int n, input int budget, input string tag);
    int k = 0;
    while (instr_count < 32'(n) && !halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, instr_count, 32'(n));
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_regs();
    regexp_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      Reg_Sel = e.r;
      #1;
      check($sformatf("reg%0d", e.r), Reg_Data, e.v);
    end
    check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    Reg_Sel = 5'd0;
    #1 rst  = 1'b0;

    // ---------------- Reset ----------------
    begin_test();
    put(32'h0, LOOP);
    repeat (3) @(negedge clk);
    check("rst_pc", PC, 32'h0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_req_low", 32'(mem_req), 32'd0);
    check("rst_be_low", 32'(mem_be), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h0);

    // ---------------- ALU sequence ----------------
    begin_test();
    put(32'h00, i_op(6'h0D, 5'd0, 5'd1, 16'h00FF));     // ori   $1,$0,0xFF
    put(32'h04, i_op(6'h08, 5'd1, 5'd2, 16'hFFFF));     // addi  $2,$1,-1
    put(32'h08, r_op(6'h00, 5'd0, 5'd2, 5'd3, 5'd4));   // sll   $3,$2,4
    put(32'h0C, r_op(6'h03, 5'd0, 5'd3, 5'd4, 5'd2));   // sra   $4,$3,2
    put(32'h10, i_op(6'h0F, 5'd0, 5'd5, 16'h8000));     // lui   $5,0x8000
    put(32'h14, r_op(6'h03, 5'd0, 5'd5, 5'd6, 5'd4));   // sra   $6,$5,4
    put(32'h18, r_op(6'h2A, 5'd5, 5'd1, 5'd7, 5'd0));   // slt   $7,$5,$1
    put(32'h1C, r_op(6'h2B, 5'd5, 5'd1, 5'd8, 5'd0));   // sltu  $8,$5,$1
    put(32'h20, r_op(6'h22, 5'd0, 5'd1, 5'd9, 5'd0));   // sub   $9,$0,$1
    put(32'h24, r_op(6'h27, 5'd0, 5'd0, 5'd10, 5'd0));  // nor   $10,$0,$0
    put(32'h28, i_op(6'h09, 5'd0, 5'd0, 16'h0005));     // addiu $0,$0,5
    put(32'h2C, i_op(6'h0E, 5'd1, 5'd11, 16'hF0F0));    // xori  $11,$1,0xF0F0
    put(32'h30, r_op(6'h06, 5'd2, 5'd10, 5'd12, 5'd0)); // srlv  $12,$10,$2
    put(32'h34, LOOP);
    exp_reg(5'd1, 32'h0000_00FF);
    exp_reg(5'd2, 32'h0000_00FE);
    exp_reg(5'd3, 32'h0000_0FE0);
    exp_reg(5'd4, 32'h0000_03F8);
    exp_reg(5'd5, 32'h8000_0000);
    exp_reg(5'd6, 32'hF800_0000);
    exp_reg(5'd7, 32'h0000_0001);
    exp_reg(5'd8, 32'h0000_0000);
    exp_reg(5'd9, 32'hFFFF_FF01);
    exp_reg(5'd10, 32'hFFFF_FFFF);
    exp_reg(5'd0, 32'h0000_0000);
    exp_reg(5'd11, 32'h0000_F00F);
    exp_reg(5'd12, 32'h0000_0003);
    release_rst(0);
    run_cycles(11);
    check("alu_cnt_11cyc", instr_count, 32'd2);
    run_cycles(1);
    check("alu_cnt_12cyc", instr_count, 32'd3);
    wait_count(13, 200, "alu_done");
    check("alu_pc_loop", PC, 32'h34);
    wait_count(15, 20, "beq_loop_retires");
    check("beq_self_loop_pc", PC, 32'h34);
    check_regs();

    // ---------------- Loads ----------------
    begin_test();
    put(32'h100, 32'h8070_F0A1);
    put(32'h00, i_op(6'h20, 5'd0, 5'd1, 16'h0100));  // lb  $1,0x100
    put(32'h04, i_op(6'h24, 5'd0, 5'd2, 16'h0101));  // lbu $2,0x101
    put(32'h08, i_op(6'h21, 5'd0, 5'd3, 16'h0102));  // lh  $3,0x102
    put(32'h0C, i_op(6'h25, 5'd0, 5'd4, 16'h0100));  // lhu $4,0x100
    put(32'h10, i_op(6'h23, 5'd0, 5'd5, 16'h0100));  // lw  $5,0x100
    put(32'h14, i_op(6'h20, 5'd0, 5'd6, 16'h0103));  // lb  $6,0x103
    put(32'h18, LOOP);
    exp_acc(1'b0, 32'h100, 4'b0001, 32'h0);
    exp_acc(1'b0, 32'h101, 4'b0010, 32'h0);
    exp_acc(1'b0, 32'h102, 4'b1100, 32'h0);
    exp_acc(1'b0, 32'h100, 4'b0011, 32'h0);
    exp_acc(1'b0, 32'h100, 4'b1111, 32'h0);
    exp_acc(1'b0, 32'h103, 4'b1000, 32'h0);
    exp_reg(5'd1, 32'hFFFF_FFA1);
    exp_reg(5'd2, 32'h0000_00F0);
    exp_reg(5'd3, 32'hFFFF_8070);
    exp_reg(5'd4, 32'h0000_F0A1);
    exp_reg(5'd5, 32'h8070_F0A1);
    exp_reg(5'd6, 32'hFFFF_FF80);
    release_rst(2);
    run_cycles(6);
    check("load_wait_cnt_6cyc", instr_count, 32'd0);
    run_cycles(1);
    check("load_wait_cnt_7cyc", instr_count, 32'd1);
    wait_count(6, 100, "loads_done");
    check_regs();

    // ---------------- Stores ----------------
    begin_test();
    put(32'h00, i_op(6'h0F, 5'd0, 5'd5, 16'h1234));  // lui $5,0x1234
    put(32'h04, i_op(6'h0D, 5'd5, 5'd5, 16'h5678));  // ori $5,$5,0x5678
    put(32'h08, i_op(6'h28, 5'd0, 5'd5, 16'h0203));  // sb  $5,0x203
    put(32'h0C, i_op(6'h29, 5'd0, 5'd5, 16'h0202));  // sh  $5,0x202
    put(32'h10, i_op(6'h2B, 5'd0, 5'd5, 16'h0204));  // sw  $5,0x204
    put(32'h14, i_op(6'h23, 5'd0, 5'd6, 16'h0200));  // lw  $6,0x200
    put(32'h18, LOOP);
    exp_acc(1'b1, 32'h203, 4'b1000, 32'h7878_7878);
    exp_acc(1'b1, 32'h202, 4'b1100, 32'h5678_5678);
    exp_acc(1'b1, 32'h204, 4'b1111, 32'h1234_5678);
    exp_acc(1'b0, 32'h200, 4'b1111, 32'h0);
    exp_reg(5'd5, 32'h1234_5678);
    exp_reg(5'd6, 32'h5678_0000);
    release_rst(0);
    run_cycles(11);
    check("store_cnt_11cyc", instr_count, 32'd2);
    run_cycles(1);
    check("store_cnt_12cyc", instr_count, 32'd3);
    wait_count(6, 100, "stores_done");
    check("sw_mem_word", mem[32'h204 >> 2], 32'h1234_5678);
    check_regs();

    // ---------------- Control flow ----------------
    begin_test();
    put(32'h00, j_op(6'h02, 26'h10));                     // j   0x40
    put(32'h04, i_op(6'h0D, 5'd0, 5'd2, 16'h0BAD));       // skipped
    put(32'h40, j_op(6'h03, 26'h18));                     // jal 0x60
    put(32'h44, i_op(6'h0D, 5'd0, 5'd3, 16'h0033));       // ori $3,$0,0x33
    put(32'h48, i_op(6'h0D, 5'd0, 5'd21, 16'h0080));      // ori $21,$0,0x80
    put(32'h4C, r_op(6'h09, 5'd21, 5'd0, 5'd20, 5'd0));   // jalr $20,$21
    put(32'h60, i_op(6'h0D, 5'd0, 5'd4, 16'h0044));       // ori $4,$0,0x44
    put(32'h64, i_op(6'h05, 5'd4, 5'd31, 16'h0004));      // bne $4,$31 (not taken)
    put(32'h68, r_op(6'h08, 5'd31, 5'd0, 5'd0, 5'd0));    // jr  $31
    put(32'h80, LOOP);
    exp_reg(5'd2, 32'h0);
    exp_reg(5'd3, 32'h33);
    exp_reg(5'd4, 32'h44);
    exp_reg(5'd20, 32'h50);
    exp_reg(5'd21, 32'h80);
    exp_reg(5'd31, 32'h44);
    release_rst(0);
    run_cycles(2);
    check("jump_cnt_2cyc", instr_count, 32'd0);
    run_cycles(1);
    check("jump_cnt_3cyc", instr_count, 32'd1);
    check("j_pc", PC, 32'h40);
    wait_count(5, 60, "ctrl_to_jr");
    check("jr_pc", PC, 32'h44);
    wait_count(8, 60, "ctrl_to_jalr");
    check("jalr_pc", PC, 32'h80);
    check_regs();

    // ---------------- Faults ----------------
    begin_test();
    put(32'h00, i_op(6'h0D, 5'd0, 5'd1, 16'h0100));  // ori $1,$0,0x100
    put(32'h04, i_op(6'h23, 5'd1, 5'd2, 16'h0002));  // lw  $2,2($1) -> 0x102
    release_rst(0);
    wait_halt(50);
    run_cycles(3);
    check("misalign_state", 32'(state), 32'd7);
    check("misalign_pc", PC, 32'h04);
    check("misalign_cnt", instr_count, 32'd1);
    check("halt_req_low", 32'(mem_req), 32'd0);

    // Reset while halted restarts the core.
    begin_test();
    #1;
    check("halt_rst_state", 32'(state), 32'd0);
    check("halt_rst_halted", 32'(halted), 32'd0);
    check("halt_rst_pc", PC, 32'h0);
    check("halt_rst_cnt", instr_count, 32'd0);
    put(32'h00, 32'hFC00_0000);  // opcode 6'h3F
    release_rst(0);
    wait_halt(20);
    check("illegal_pc", PC, 32'h0);
    check("illegal_cnt", instr_count, 32'd0);

    begin_test();
    put(32'h00, i_op(6'h0D, 5'd0, 5'd1, 16'h0077));
    put(32'h04, LOOP);
    exp_reg(5'd1, 32'h77);
    release_rst(0);
    wait_count(1, 20, "restart_retire");
    check_regs();

    // Reset during a stalled data request abandons it.
    begin_test();
    put(32'h00, i_op(6'h23, 5'd0, 5'd1, 16'h0100));  // lw $1,0x100
    release_rst(10);
    run_cycles(5);
    check("midreq_in_mem", 32'(state), 32'd3);
    begin_test();
    #1;
    check("midreq_rst_req_low", 32'(mem_req), 32'd0);
    release_rst(0);
    #1;
    check("midreq_refetch_req", 32'(mem_req), 32'd1);
    check("midreq_refetch_addr", mem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
